// File: rtl/seq_div.sv
// seq_div: restoring unsigned divider, one quotient bit per clock, start/done handshake.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH:0] a, a_sh, d, a_nxt, nb;
  logic [WIDTH+1:0] c;
  logic [WIDTH-1:0] q, b, q_nxt;
  logic [CW-1:0] count;
  logic unused;
  assign a_sh = {a[WIDTH-1:0], q[WIDTH-1]};
  assign nb = ~{1'b0, b};
  assign c[0] = 1'b1;
  // A' - B as A' + ~B + 1 through a ripple chain; d[WIDTH] set means A' < B
  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    fa u_fa (.a(a_sh[i]), .b(nb[i]), .ci(c[i]), .s(d[i]), .co(c[i+1]));
    assign a_nxt[i] = d[WIDTH] ? a_sh[i] : d[i];
  end
  assign q_nxt = {q[WIDTH-2:0], ~d[WIDTH]};
  assign unused = ^{a[WIDTH], c[WIDTH+1]};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      b           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && divisor != '0) begin
            a           <= '0;
            q           <= dividend;
            b           <= divisor;
            count       <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= RUN;
          end else if (start) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        RUN: begin
          a     <= a_nxt;
          q     <= q_nxt;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            quotient  <= q_nxt;
            remainder <= a_nxt[WIDTH-1:0];
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed checks of seq_div (WIDTH=8) with a bench-side reference.
module tb_seq_div;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic [7:0] quotient, remainder;
  logic busy, done, div_by_zero;
  int tests = 0, fails = 0;

  seq_div #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(inout int lat);
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic expect_div(input string tag, input logic [7:0] x, input logic [7:0] y);
    int lat;
    logic b1;
    logic [7:0] eq, er;
    eq = (y != 0) ? x / y : 8'hFF;
    er = (y != 0) ? x % y : x;
    start = 1'b1; dividend = x; divisor = y;
    @(posedge clk); #1;
    lat = 1; start = 1'b0; b1 = busy;
    wait_done(lat);
    check({tag, ".busy1"}, 32'(b1), 1);
    check({tag, ".lat"}, lat, (y != 0) ? 9 : 1);
    check({tag, ".q"}, quotient, eq);
    check({tag, ".r"}, remainder, er);
    check({tag, ".dz"}, div_by_zero, (y == 0) ? 1 : 0);
    if (y != 0) begin
      check({tag, ".inv"}, int'(quotient) * int'(y) + int'(remainder), x);
      check({tag, ".rlt"}, 32'(remainder < y), 1);
    end
    @(posedge clk); #1;
    check({tag, ".done_off"}, done, 0);
    check({tag, ".busy_off"}, busy, 0);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [7:0] bx [5] = '{8'd255, 8'd5, 8'd0, 8'd255, 8'd128};
    logic [7:0] by [5] = '{8'd1, 8'd9, 8'd13, 8'd255, 8'd2};
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.q", quotient, 0);
    check("rst.r", remainder, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.dz", div_by_zero, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle.busy", busy, 0);

    expect_div("d200_7", 8'd200, 8'd7);
    check("d200_7.q28", quotient, 28);
    for (int i = 0; i < 5; i++) expect_div($sformatf("bnd%0d", i), bx[i], by[i]);
    expect_div("d37_0", 8'd37, 8'd0);
    check("d37_0.qff", quotient, 8'hFF);
    expect_div("d10_3", 8'd10, 8'd3);

    repeat (5) @(posedge clk);
    #1;
    check("hold.q", quotient, 3);
    check("hold.r", remainder, 1);

    // second start and operand change mid-run must not disturb 100/3
    start = 1'b1; dividend = 8'd100; divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      lat++;
      pulses += int'(done);
    end
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    wait_done(lat);
    pulses += int'(done);
    check("mid.lat", lat, 9);
    check("mid.pulses", pulses, 1);
    check("mid.q", quotient, 33);
    check("mid.r", remainder, 1);
    @(posedge clk); #1;
    check("mid.done_off", done, 0);
    check("mid.busy_off", busy, 0);
    @(posedge clk); #1;
    check("held.busy", busy, 1);
    start = 1'b0; lat = 1;
    wait_done(lat);
    check("held.lat", lat, 9);
    check("held.q", quotient, 10);
    check("held.r", remainder, 0);
    @(posedge clk); #1;

    // asynchronous reset during iteration 5
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst.q", quotient, 0);
    check("arst.r", remainder, 0);
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    check("arst.dz", div_by_zero, 0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      pulses += int'(done);
    end
    check("arst.nodone", pulses, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    expect_div("d9_2", 8'd9, 8'd2);

    for (int x = 0; x < 256; x += 17)
      for (int y = 0; y < 256; y += 15)
        expect_div($sformatf("sw%0d_%0d", x, y), 8'(x), 8'(y));
    for (int i = 0; i < 150; i++)
      expect_div($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
